// File: rtl/fullconnblockfp_l2.sv
// fullconnblockfp_l2: 8-input / 5-output stochastic fully-connected layer with saturating state neurons.
// Define FP_DERIV_EN to add the z history and the zp derivative outputs; otherwise zp is tied low.
module fullconnblockfp_l2 #(
  parameter int S_W    = 5,
  parameter int WARMUP = 64,
  parameter int ZP_DLY = 3
) (
  input  logic       CLK,
  input  logic       INIT,
  input  logic       EN,
  input  logic [7:0] a,
  input  logic [7:0] alpha_j_0,
  input  logic [7:0] alpha_j_1,
  input  logic [7:0] alpha_j_2,
  input  logic [7:0] alpha_j_3,
  input  logic [7:0] alpha_j_4,
  input  logic [7:0] SIGN_alpha_j_0,
  input  logic [7:0] SIGN_alpha_j_1,
  input  logic [7:0] SIGN_alpha_j_2,
  input  logic [7:0] SIGN_alpha_j_3,
  input  logic [7:0] SIGN_alpha_j_4,
  output logic [4:0] z,
  output logic [4:0] zp,
  output logic       z_valid
);
  localparam int SMAX = 2**S_W - 1;
  localparam int CW = $clog2(WARMUP + 1);
  localparam logic [S_W-1:0] MID = S_W'(1) << (S_W - 1);
  logic [4:0][7:0] w, sg;
  logic [4:0][S_W-1:0] s_q, s_d;
  logic [4:0] z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign w  = {alpha_j_4, alpha_j_3, alpha_j_2, alpha_j_1, alpha_j_0};
  assign sg = {SIGN_alpha_j_4, SIGN_alpha_j_3, SIGN_alpha_j_2, SIGN_alpha_j_1, SIGN_alpha_j_0};
  function automatic logic [S_W-1:0] step(input logic [S_W-1:0] s, input logic [7:0] act, wt, neg);
    logic [3:0] p, n;
    logic signed [4:0] d;
    logic signed [S_W+5:0] t;
    p = '0;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      p += 4'(act[i] & wt[i] & ~neg[i]);
      n += 4'(act[i] & wt[i] & neg[i]);
    end
    d = $signed({1'b0, p}) - $signed({1'b0, n});
    t = $signed({6'b0, s}) + (S_W+6)'(d);
    // clamp instead of wrap so a saturated neuron leaves saturation on the next opposite step
    return t[S_W+5] ? '0 : (t > (S_W+6)'(SMAX)) ? S_W'(SMAX) : t[S_W-1:0];
  endfunction
  always_comb begin
    s_d = s_q;
    z_d = z_q;
    if (EN)
      for (int k = 0; k < 5; k++) begin
        s_d[k] = step(s_q[k], a, w[k], sg[k]);
        z_d[k] = s_d[k][S_W-1];
      end
    cnt_d = (EN && cnt_q != CW'(WARMUP)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (INIT) begin
      s_q   <= {5{MID}};
      z_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      z_q   <= z_d;
      cnt_q <= cnt_d;
    end
  end
  assign z = z_q;
  assign z_valid = cnt_q == CW'(WARMUP);
`ifdef FP_DERIV_EN
  logic [ZP_DLY-1:0][4:0] h_q, h_d;
  always_comb begin
    h_d = h_q;
    if (EN) begin
      h_d[0] = z_q;
      for (int j = 1; j < ZP_DLY; j++) h_d[j] = h_q[j-1];
    end
  end
  always_ff @(posedge CLK) begin
    if (INIT) h_q <= '0;
    else h_q <= h_d;
  end
  assign zp = z_q & ~h_q[ZP_DLY-1];
`else
  assign zp = '0;
`endif
endmodule

// File: tb/tb_fullconnblockfp_l2.sv
// tb_fullconnblockfp_l2: directed checks of reset, saturation, balance, parallel update, hold, derivative and warm-up.
module tb_fullconnblockfp_l2;
  logic CLK = 0, INIT = 1, EN = 0;
  logic [7:0] a = 0;
  logic [7:0] al0 = 0, al1 = 0, al2 = 0, al3 = 0, al4 = 0;
  logic [7:0] sg0 = 0, sg1 = 0, sg2 = 0, sg3 = 0, sg4 = 0;
  logic [4:0] z, zp;
  logic z_valid;
  int n_vec = 0, n_err = 0;
  logic [3:0] zp_exp [4] = '{4'h1, 4'h1, 4'h1, 4'h0};
  fullconnblockfp_l2 dut (
    .CLK(CLK), .INIT(INIT), .EN(EN), .a(a),
    .alpha_j_0(al0), .alpha_j_1(al1), .alpha_j_2(al2), .alpha_j_3(al3), .alpha_j_4(al4),
    .SIGN_alpha_j_0(sg0), .SIGN_alpha_j_1(sg1), .SIGN_alpha_j_2(sg2), .SIGN_alpha_j_3(sg3), .SIGN_alpha_j_4(sg4),
    .z(z), .zp(zp), .z_valid(z_valid)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    {al0, al1, al2, al3, al4} = '0;
    {sg0, sg1, sg2, sg3, sg4} = '0;
  endtask
  task automatic rst();
    INIT = 1;
    EN = 1;
    tick();
    INIT = 0;
  endtask
  task automatic chk_s(input string tag, input int k, input int exp);
    chk(tag, 32'(dut.s_q[k]), 32'(exp));
  endtask
  initial begin
    a = 8'($urandom); al0 = 8'($urandom); al1 = 8'($urandom); al2 = 8'($urandom);
    al3 = 8'($urandom); al4 = 8'($urandom); sg0 = 8'($urandom); sg3 = 8'($urandom);
    INIT = 1; EN = 1;
    tick(); tick();
    chk("rst_z", 32'(z), 0);
    chk("rst_zp", 32'(zp), 0);
    chk("rst_valid", 32'(z_valid), 0);
    for (int k = 0; k < 5; k++) chk_s("rst_s", k, 16);
    INIT = 0; clr(); a = 8'hFF; al0 = 8'hFF;
    tick(); chk_s("pos_e1_s0", 0, 24); chk("pos_e1_z", 32'(z), 32'h1F);
    tick(); chk_s("pos_e2_s0", 0, 31);
    tick(); chk_s("pos_e3_s0", 0, 31);
    sg0 = 8'hFF;
    tick(); chk_s("pos_leave_s0", 0, 23); chk("pos_leave_z0", 32'(z[0]), 1);
    tick(); chk_s("pos_down_s0", 0, 15); chk("pos_down_z0", 32'(z[0]), 0);
    rst(); clr(); a = 8'hFF; al0 = 8'hFF; sg0 = 8'hFF;
    tick(); chk_s("neg_e1_s0", 0, 8); chk("neg_e1_z", 32'(z), 32'h1E);
    tick(); chk_s("neg_e2_s0", 0, 0);
    tick(); chk_s("neg_e3_s0", 0, 0);
    sg0 = 8'h00;
    tick(); chk_s("neg_leave_s0", 0, 8);
    rst(); clr(); a = 8'hFF; al1 = 8'hFF; sg1 = 8'hF0;
    for (int e = 0; e < 3; e++) begin
      tick(); chk_s("bal_s1", 1, 16); chk("bal_z1", 32'(z[1]), 1);
    end
    rst(); clr(); a = 8'hFF;
    al0 = 8'hFF; al1 = 8'hFF; sg1 = 8'hF0; al2 = 8'h3C; sg2 = 8'h08;
    al3 = 8'hFF; sg3 = 8'hFF; al4 = 8'h01; sg4 = 8'h01;
    tick();
    chk_s("par1_s0", 0, 24); chk_s("par1_s1", 1, 16); chk_s("par1_s2", 2, 18);
    chk_s("par1_s3", 3, 8); chk_s("par1_s4", 4, 15); chk("par1_z", 32'(z), 32'h07);
    tick();
    chk_s("par2_s0", 0, 31); chk_s("par2_s2", 2, 20); chk_s("par2_s3", 3, 0);
    chk_s("par2_s4", 4, 14); chk("par2_z", 32'(z), 32'h07);
    EN = 0; sg0 = 8'hFF; al3 = 8'h00;
    tick();
    chk_s("hold_s0", 0, 31); chk_s("hold_s3", 3, 0); chk("hold_z", 32'(z), 32'h07);
    a = 8'h0F; clr(); al2 = 8'h3C;
    EN = 1; INIT = 1;
    tick();
    INIT = 0;
    tick(); chk_s("mix_s2", 2, 18);
    rst(); clr(); a = 8'hFF; al0 = 8'hFF; sg0 = 8'hFF;
    tick(); chk("der_pre_z0", 32'(z[0]), 0); chk("der_pre_zp0", 32'(zp[0]), 0);
    sg0 = 8'h00;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("der_z0", 32'(z[0]), 1);
`ifdef FP_DERIV_EN
      chk("der_zp0", 32'(zp[0]), 32'(zp_exp[e][0]));
`else
      chk("der_zp0", 32'(zp[0]), 0);
`endif
    end
    rst(); clr(); a = 8'($urandom);
    for (int c = 1; c <= 128; c++) begin
      EN = c[0];
      tick();
      if (c == 126) chk("warm_126", 32'(z_valid), 0);
      if (c == 127) chk("warm_127", 32'(z_valid), 1);
    end
    chk("warm_hold", 32'(z_valid), 1);
    EN = 1;
    tick(); tick(); chk("warm_sat", 32'(z_valid), 1);
    INIT = 1;
    tick(); chk("warm_init", 32'(z_valid), 0);
    INIT = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fullconnblockfp_l2.md
FULLCONNBLOCKFP_L2 -- requirements
Module: fullconnblockfp_l2

Interface
REQ-001 Parameter S_W, default 5: width of each neuron's activation state counter; 2^S_W states.
REQ-002 Parameter WARMUP, default 64: number of enabled cycles before z_valid asserts.
REQ-003 Parameter ZP_DLY, default 3, legal range 1..15: depth of the z history used for derivative generation.
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 INIT  in  1  reset, synchronous, active-high.
REQ-006 EN  in  1  advance enable; when low, all state holds.
REQ-007 a  in  8  layer-1 activation bitstreams, one bit per input neuron i.
REQ-008 alpha_j_0 .. alpha_j_4  in  8 each  weight magnitude bitstreams; bit i of alpha_j_k is the weight from input i to output neuron k.
REQ-009 SIGN_alpha_j_0 .. SIGN_alpha_j_4  in  8 each  weight sign bitstreams; 1 = negative.
REQ-010 z  out  5  output neuron activation bitstreams; these feed the backprop layer's z input.
REQ-011 zp  out  5  activation-derivative bitstreams; these feed the backprop layer's zp input.
REQ-012 z_valid  out  1  high once the warm-up window has elapsed.

Function
REQ-013 Per neuron k and per cycle, pos_k SHALL be the count of i where a[i]=1, alpha_j_k[i]=1 and SIGN_alpha_j_k[i]=0; range 0..8.
REQ-014 Per neuron k and per cycle, neg_k SHALL be the same count but with SIGN_alpha_j_k[i]=1; range 0..8.
REQ-015 The step d_k = pos_k - neg_k SHALL be held as a signed value of at least 5 bits; range -8..+8.
REQ-016 On each edge with EN=1 and INIT=0, the unsigned state S_k SHALL update to S_k + d_k, clamped to 0..2^S_W-1 with no wrap-around.
REQ-017 On each such edge, z[k] SHALL register 1 when the updated S_k >= 2^(S_W-1), else 0; latency from inputs to z is exactly one cycle.
REQ-018 Each neuron SHALL keep a ZP_DLY-deep shift history of z; the history shifts only on enabled edges.
REQ-019 zp[k] SHALL equal z[k] AND NOT (z[k] delayed ZP_DLY enabled cycles); this is a decorrelated estimate of z(1-z).
REQ-020 An enabled-cycle counter SHALL increment on each edge with EN=1 and saturate at WARMUP; z_valid = (counter == WARMUP).
REQ-021 With EN=0, S_k, z, the z history, the counter and z_valid SHALL hold their values.
REQ-022 All five neurons SHALL update in parallel and independently.
REQ-023 Simultaneous saturation and opposite-sign steps SHALL be handled by the clamp alone; a saturated counter leaves saturation on the next step of opposite sign.

Reset
REQ-024 INIT=1 SHALL take priority over EN on any edge, including mid-operation.
REQ-025 Reset values:
- S_k = 2^(S_W-1) (16 at default)
- z = 0
- z history = 0
- zp = 0
- warm-up counter = 0
- z_valid = 0
REQ-026 The first enabled edge after INIT deasserts SHALL compute z from the midpoint state.

Configuration
REQ-027 Macro FP_DERIV_EN defined: the z history and zp logic SHALL be present as specified in REQ-018 and REQ-019.
REQ-028 Macro FP_DERIV_EN undefined: the z history SHALL be omitted, zp SHALL be tied to 5'b0, and all other behaviour SHALL be unchanged.

Verification
REQ-029 Reset: hold INIT=1 for 2 cycles with EN=1 and random inputs -> z=0, zp=0, z_valid=0, S_0..S_4=16.
REQ-030 Positive saturation: a=8'hFF, alpha_j_0=8'hFF, SIGN_alpha_j_0=8'h00, EN=1 -> after edge 1 S_0=24 and z[0]=1; after edge 2 S_0=31; S_0 stays 31 on edge 3.
REQ-031 Negative saturation: same as REQ-030 with SIGN_alpha_j_0=8'hFF -> after edge 1 S_0=8 and z[0]=0; after edge 2 S_0=0; S_0 stays 0 on edge 3.
REQ-032 Balanced weights: a=8'hFF, alpha_j_1=8'hFF, SIGN_alpha_j_1=8'hF0 -> d_1=0, S_1 stays 16, z[1]=1 from edge 1 onward.
REQ-033 Warm-up gating: toggle EN 1/0 alternately -> z_valid rises on the edge of the 64th enabled cycle (127th clock); INIT mid-run clears z_valid on the next edge.
REQ-034 Derivative: with FP_DERIV_EN defined, ZP_DLY=3, and z[0] rising 0->1 and then staying 1 -> zp[0]=1 for exactly 3 enabled cycles, then 0; without the macro, zp=0 throughout.
